// File: rtl/mem_access_ctrl_pkg.sv
// +------------------------------------------------------------------+
// | mem_access_ctrl_pkg                                              |
// | Shared widths, memory map base and MEM-stage FSM encoding.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mem_access_ctrl_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int MEM_BASE_DEFAULT  = 1024;
  localparam int TIMER_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Misalignment and below-base checks only matter when an access is requested;
  // ALU-only instructions freely produce small or odd results.
  function automatic logic is_illegal(
    input logic                rd,
    input logic                wr,
    input logic [WORD_LEN-1:0] addr,
    input logic [WORD_LEN-1:0] base
  );
    logic acc;
    acc = rd | wr;
    return acc & ((rd & wr) | (addr[1:0] != 2'b00) | (addr < base));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_wait_timer.sv
// +------------------------------------------------------------------+
// | wait_timer                                                       |
// | 8-bit WAIT-cycle counter with clear/enable and expiry compare.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module wait_timer
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] r_count;

  // The count holds the number of the current WAIT cycle, so a launch loads 1
  // and expiry lands exactly on the TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= TIMER_W'(1);
    end else if (en && (r_count != {TIMER_W{1'b1}})) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign expired = (r_count == TIMER_W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// +------------------------------------------------------------------+
// | mem_access_ctrl                                                  |
// | MEM-stage req/ack data-memory controller with pipeline freeze.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_BASE = MEM_BASE_DEFAULT,
  parameter int TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         WB_EN_IN,
  input  logic                         MEM_R_EN_IN,
  input  logic                         MEM_W_EN_IN,
  input  logic [WORD_LEN-1:0]          ALUResIn,
  input  logic [WORD_LEN-1:0]          STValIn,
  input  logic [REG_FILE_ADDR_LEN-1:0] destIn,
  output logic                         freeze,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [WORD_LEN-1:0]          mem_addr,
  output logic [WORD_LEN-1:0]          mem_wdata,
  input  logic                         mem_ack,
  input  logic [WORD_LEN-1:0]          mem_rdata,
  output logic                         WB_EN,
  output logic                         MEM_R_EN,
  output logic [WORD_LEN-1:0]          ALURes,
  output logic [WORD_LEN-1:0]          MEMRes,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic                         access_err,
  output logic                         bus_err
);

  localparam logic [WORD_LEN-1:0] C_BASE = WORD_LEN'(MEM_BASE);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [WORD_LEN-1:0] r_mem_addr;
  logic [WORD_LEN-1:0] r_mem_wdata;
  logic [WORD_LEN-1:0] r_memres;
  logic                r_bus_err;

  logic                w_access;
  logic                w_illegal;
  logic                w_launch;
  logic                w_wait_ack;
  logic                w_wait_timeout;
  logic                w_expired;
  logic                w_freeze;
  logic                w_access_err;
  logic [WORD_LEN-1:0] w_addr_off;

  assign w_access   = MEM_R_EN_IN | MEM_W_EN_IN;
  assign w_illegal  = is_illegal(MEM_R_EN_IN, MEM_W_EN_IN, ALUResIn, C_BASE);
  assign w_addr_off = ALUResIn - C_BASE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_launch       = 1'b0;
    w_wait_ack     = 1'b0;
    w_wait_timeout = 1'b0;
    w_freeze       = 1'b0;
    w_access_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_access_err = w_illegal;
        if (w_access && !w_illegal) begin
          w_launch     = 1'b1;
          w_freeze     = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_freeze = 1'b1;
        // Ack arriving on the expiry cycle takes priority over the timeout.
        if (mem_ack) begin
          w_wait_ack   = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_wait_timeout = 1'b1;
          w_next_state   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Inputs still hold the just-completed instruction; never relaunch here.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_memres    <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= MEM_W_EN_IN;
        r_mem_addr  <= w_addr_off >> 2;
        r_mem_wdata <= STValIn;
      end else if (w_wait_ack || w_wait_timeout) begin
        r_mem_req <= 1'b0;
      end
      if (w_wait_ack && !r_mem_we) begin
        r_memres <= mem_rdata;
      end
      r_bus_err <= w_wait_timeout;
    end
  end

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_launch),
    .en      (r_state == ST_WAIT),
    .expired (w_expired)
  );

  assign freeze     = w_freeze;
  assign access_err = w_access_err;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign MEMRes     = r_memres;
  assign bus_err    = r_bus_err;

  // A stalled or faulted instruction retires as a bubble.
  assign WB_EN    = WB_EN_IN & ~w_freeze & ~w_access_err
                    & ~((r_state == ST_DONE) & r_bus_err);
  assign MEM_R_EN = MEM_R_EN_IN & ~w_freeze;
  assign ALURes   = ALUResIn;
  assign dest     = destIn;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// +------------------------------------------------------------------+
// | tb_mem_access_ctrl                                               |
// | Scoreboard bench: driver queues expectations, monitor compares.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WB_EN_IN = 1'b0, MEM_R_EN_IN = 1'b0, MEM_W_EN_IN = 1'b0;
  logic [31:0] ALUResIn = '0, STValIn = '0;
  logic [4:0]  destIn = '0;
  logic        freeze, mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        WB_EN, MEM_R_EN, access_err, bus_err;
  logic [31:0] ALURes, MEMRes;
  logic [4:0]  dest;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_BASE(1024), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALUResIn(ALUResIn), .STValIn(STValIn), .destIn(destIn),
    .freeze(freeze), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALURes(ALURes), .MEMRes(MEMRes),
    .dest(dest), .access_err(access_err), .bus_err(bus_err)
  );

  typedef struct {
    logic        wb_en, mem_r_en, access_err, bus_err, we;
    logic [31:0] memres, alures, addr, wdata;
    logic [4:0]  dest;
    int          fcyc, rcyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic tb_valid = 1'b0;
  int   ack_delay = 0;
  logic [31:0] rdata_val = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: ack in the Nth cycle that mem_req is high (0 = never)
  int mcnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) mcnt++; else mcnt = 0;
      mem_ack   = mem_req && (ack_delay != 0) && (mcnt == ack_delay);
      mem_rdata = mem_ack ? rdata_val : 32'h0;
    end
  end

  // Monitor: counts stall cycles, latches request fields, checks on retire
  int          fcnt = 0, rcnt = 0;
  logic        lat_we = 1'b0;
  logic [31:0] lat_addr = '0, lat_wdata = '0;
  always @(negedge clk) begin
    if (!tb_valid) begin
      fcnt = 0; rcnt = 0;
    end else if (freeze) begin
      fcnt++;
      if (mem_req) begin
        rcnt++; lat_we = mem_we; lat_addr = mem_addr; lat_wdata = mem_wdata;
      end
    end else if (sb.size() == 0) begin
      chk("unexpected_retire", 32'd1, 32'd0);
    end else begin
      exp_t e;
      e = sb.pop_front();
      chk("WB_EN", {31'd0, WB_EN}, {31'd0, e.wb_en});
      chk("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, e.mem_r_en});
      chk("access_err", {31'd0, access_err}, {31'd0, e.access_err});
      chk("bus_err", {31'd0, bus_err}, {31'd0, e.bus_err});
      chk("MEMRes", MEMRes, e.memres);
      chk("ALURes", ALURes, e.alures);
      chk("dest", {27'd0, dest}, {27'd0, e.dest});
      chk("freeze_cycles", fcnt, e.fcyc);
      chk("req_cycles", rcnt, e.rcyc);
      if (e.rcyc != 0) begin
        chk("mem_we", {31'd0, lat_we}, {31'd0, e.we});
        chk("mem_addr", lat_addr, e.addr);
        if (e.we) chk("mem_wdata", lat_wdata, e.wdata);
      end
      fcnt = 0; rcnt = 0;
    end
  end

  function automatic exp_t mk(input logic wb, mrd, aerr, berr, we,
                              input logic [31:0] mres, alu, addr, wd,
                              input logic [4:0] d, input int fc, rc);
    exp_t e;
    e.wb_en = wb; e.mem_r_en = mrd; e.access_err = aerr; e.bus_err = berr; e.we = we;
    e.memres = mres; e.alures = alu; e.addr = addr; e.wdata = wd; e.dest = d;
    e.fcyc = fc; e.rcyc = rc;
    return e;
  endfunction

  task automatic run(input exp_t e, input logic r, w, wb,
                     input logic [31:0] alu, st, input logic [4:0] d,
                     input int dly, input logic [31:0] rd);
    bit done;
    done = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    MEM_R_EN_IN = r; MEM_W_EN_IN = w; WB_EN_IN = wb;
    ALUResIn = alu; STValIn = st; destIn = d;
    ack_delay = dly; rdata_val = rd; tb_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!freeze) begin done = 1; break; end
    end
    if (!done) begin
      chk("retire_timeout", 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_back());
    end
    @(posedge clk); #1;
    tb_valid = 1'b0;
    MEM_R_EN_IN = 0; MEM_W_EN_IN = 0; WB_EN_IN = 0;
    ALUResIn = '0; STValIn = '0; destIn = '0;
  endtask

  initial begin
    #3;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_WB_EN", {31'd0, WB_EN}, 32'd0);
    chk("rst_MEMRes", MEMRes, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // ALU-only instruction: same-cycle pass-through
    run(mk(1,0,0,0,0, 32'h0, 32'h55, 0, 0, 5'd7, 0, 0), 0,0,1, 32'h55, 0, 5'd7, 0, 0);
    // Load 1032, ack after 3
    run(mk(1,1,0,0,0, 32'hDEADBEEF, 32'd1032, 32'd2, 0, 5'd3, 4, 3),
        1,0,1, 32'd1032, 0, 5'd3, 3, 32'hDEADBEEF);
    // Store 0x1234 to 1024, ack after 1; MEMRes untouched
    run(mk(0,0,0,0,1, 32'hDEADBEEF, 32'd1024, 32'd0, 32'h1234, 5'd0, 2, 1),
        0,1,0, 32'd1024, 32'h1234, 5'd0, 1, 32'hFFFFFFFF);
    // Misaligned, double-enable, below-base
    run(mk(0,1,1,0,0, 32'hDEADBEEF, 32'd1026, 0, 0, 5'd4, 0, 0), 1,0,1, 32'd1026, 0, 5'd4, 1, 0);
    run(mk(0,1,1,0,0, 32'hDEADBEEF, 32'd1028, 0, 0, 5'd5, 0, 0), 1,1,1, 32'd1028, 0, 5'd5, 1, 0);
    run(mk(0,1,1,0,0, 32'hDEADBEEF, 32'd1000, 0, 0, 5'd6, 0, 0), 1,0,1, 32'd1000, 0, 5'd6, 1, 0);
    // No ack: 15 WAIT cycles then bus_err
    run(mk(0,1,0,1,0, 32'hDEADBEEF, 32'd1040, 32'd4, 0, 5'd8, 16, 15),
        1,0,1, 32'd1040, 0, 5'd8, 0, 0);
    // Ack on the expiry cycle wins
    run(mk(1,1,0,0,0, 32'hCAFEF00D, 32'd1036, 32'd3, 0, 5'd9, 16, 15),
        1,0,1, 32'd1036, 0, 5'd9, 15, 32'hCAFEF00D);

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    MEM_R_EN_IN = 1; WB_EN_IN = 1; ALUResIn = 32'd1044; ack_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    #1;
    rst = 1'b0;
    MEM_R_EN_IN = 0; WB_EN_IN = 0; ALUResIn = '0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_freeze", {31'd0, freeze}, 32'd0);
    chk("async_MEMRes", MEMRes, 32'd0);
    @(negedge clk); rst = 1'b1;

    run(mk(1,1,0,0,0, 32'h0BADF00D, 32'd1048, 32'd6, 0, 5'd31, 3, 2),
        1,0,1, 32'd1048, 0, 5'd31, 2, 32'h0BADF00D);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
